// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter; define PS2_TX_RETRY_EN to retry failed frames up to twice
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int RTS_CYCLES = 20,
    parameter int START_TIMEOUT = 150000,
    parameter int EDGE_TIMEOUT = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int M1 = START_TIMEOUT > EDGE_TIMEOUT ? START_TIMEOUT : EDGE_TIMEOUT;
    localparam int M2 = INHIBIT_CYCLES > RTS_CYCLES ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int TW = $clog2((M1 > M2 ? M1 : M2) + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE, ERR} state_t;

    state_t state;
    logic [TW-1:0] timer;
    logic [3:0] n;
    logic [8:0] sr;
    logic [7:0] data_q;
    logic [2:0] clk_sync;
    logic [1:0] data_sync;
    logic clk_s, data_s, fall, expired, fail, retry;
    logic [1:0] code;

    assign clk_s = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall = clk_sync[2] & ~clk_sync[1];
    assign rx_inhibit = tx_busy;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] tries;
    assign retry = code != 2'b01 && tries != 2'd2;
`else
    assign retry = 1'b0;
`endif

    // bring the open-drain bus lines into the clock domain; idle bus reads high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            data_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // abort detection: timeouts and missing ack; a coincident falling edge beats the timeout
    always_comb begin
        expired = timer == '0;
        fail = (state == SEND && !fall && expired)
            || (state == ACK && (fall ? data_s : expired))
            || (state == WAIT_IDLE && !(clk_s && data_s) && expired);
        code = (state == SEND && n == '0) ? 2'b01 : (state == ACK && fall) ? 2'b11 : 2'b10;
    end

    // transfer sequencer: inhibit, request-to-send, clock out 10 bits on device edges, check ack
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            n <= '0;
            sr <= '0;
            data_q <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            tx_error <= 1'b0;
            err_code <= 2'b00;
            ps2_clk_oe <= 1'b0;
            ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            tries <= 2'd0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_error <= 1'b0;
            if (fail) begin
                err_code <= code;
                ps2_data_oe <= 1'b0;
                if (retry) begin
                    state <= INHIBIT;
                    timer <= TW'(INHIBIT_CYCLES - 1);
                    ps2_clk_oe <= 1'b1;
`ifdef PS2_TX_RETRY_EN
                    tries <= tries + 2'd1;
`endif
                end else begin
                    state <= ERR;
                    ps2_clk_oe <= 1'b0;
                    tx_error <= 1'b1;
                    tx_busy <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: if (tx_start) begin
                        state <= INHIBIT;
                        data_q <= tx_data;
                        timer <= TW'(INHIBIT_CYCLES - 1);
                        ps2_clk_oe <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        tx_busy <= 1'b1;
                        err_code <= 2'b00;
`ifdef PS2_TX_RETRY_EN
                        tries <= 2'd0;
`endif
                    end
                    INHIBIT: if (expired) begin
                        state <= RTS;
                        timer <= TW'(RTS_CYCLES - 1);
                        ps2_data_oe <= 1'b1;
                    end else timer <= timer - TW'(1);
                    RTS: if (expired) begin
                        state <= SEND;
                        timer <= TW'(START_TIMEOUT);
                        ps2_clk_oe <= 1'b0;
                        n <= '0;
                        sr <= {~^data_q, data_q};
                    end else timer <= timer - TW'(1);
                    // shifting in ones makes the tenth edge present the stop bit
                    SEND: if (fall) begin
                        n <= n + 4'd1;
                        timer <= TW'(EDGE_TIMEOUT);
                        ps2_data_oe <= ~sr[0];
                        sr <= {1'b1, sr[8:1]};
                        if (n == 4'd9) state <= ACK;
                    end else timer <= timer - TW'(1);
                    ACK: if (fall) begin
                        state <= WAIT_IDLE;
                        timer <= TW'(EDGE_TIMEOUT);
                    end else timer <= timer - TW'(1);
                    WAIT_IDLE: if (clk_s && data_s) begin
                        state <= DONE;
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                    end else timer <= timer - TW'(1);
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
